// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the RV32 run/halt/step sequencer: state encoding,
// stop-cause codes and the EBREAK opcode.
package core_ctrl_defs;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    HALT = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HALT = 2'd1,
    CAUSE_STEP = 2'd2,
    CAUSE_BRK  = 2'd3
  } cause_e;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/core_run_ctrl_instret_counter.sv
// Retired-instruction counter: W-bit, enabled, wraps modulo 2^W,
// synchronous active-low clear.
module instret_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: rst is sampled only at the clock edge, and sequential state is
  // written with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/step sequencer for the single-cycle RV32 core.
// Define CORE_RUN_CTRL_HW_BREAKPOINT_EN to enable the PC address breakpoint.
module core_run_ctrl
  import core_ctrl_defs::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int BOOT_HOLD = 4,
  parameter int START_RUN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instruction,
  input  logic             bp_valid,
  input  logic [XLEN-1:0]  bp_addr,
  output logic             pc_en,
  output logic             wr_en,
  output logic             halted,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] instret
);

  localparam int BOOT_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_HOLD - 1);

  run_state_e        state;
  cause_e            cause_q;
  logic [BOOT_W-1:0] boot_cnt;
  logic              skip;
  logic              is_ebreak;
  logic              bp_hit;
  logic              stop_hit;

  assign is_ebreak = (instruction == XLEN'(EBREAK_INSN));

`ifdef CORE_RUN_CTRL_HW_BREAKPOINT_EN
  assign bp_hit = bp_valid && (pc == bp_addr);
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = &{1'b0, bp_valid, bp_addr, pc};
`endif

  // skip lets the instruction we stopped on execute once after resuming.
  assign stop_hit = (is_ebreak || bp_hit) && !skip;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pc_en = 1'b0;
    if (state == RUN || state == STEP) begin
      pc_en = !stop_hit;
    end
  end

  // A resumed EBREAK advances the PC but must not write architectural state.
  assign wr_en  = pc_en && !is_ebreak;
  assign halted = (state == HALT);
  assign cause  = cause_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BOOT;
      boot_cnt <= '0;
      cause_q  <= CAUSE_NONE;
      skip     <= 1'b0;
    end else begin
      if (pc_en) begin
        skip <= 1'b0;
      end
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 1'b1;
          if (boot_cnt == BOOT_LAST) begin
            state <= (START_RUN != 0) ? RUN : HALT;
          end
        end
        HALT: begin
          if (run_req) begin
            state <= RUN;
            skip  <= 1'b1;
          end else if (step_req) begin
            state <= STEP;
            skip  <= 1'b1;
          end
        end
        RUN: begin
          if (stop_hit) begin
            state   <= HALT;
            cause_q <= CAUSE_BRK;
          end else if (halt_req) begin
            state   <= HALT;
            cause_q <= CAUSE_HALT;
          end
        end
        STEP: begin
          state   <= HALT;
          cause_q <= stop_hit ? CAUSE_BRK : CAUSE_STEP;
        end
        default: state <= BOOT;
      endcase
    end
  end

  instret_counter #(
    .W (CNT_W)
  ) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_en),
    .count (instret)
  );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: hand-computed vector table, a
// breakpoint/wrap sequence, then random stimulus against a behavioural model.
module tb_core_run_ctrl;

  localparam int BOOT_HOLD = 4;
  localparam int START_RUN = 1;
  localparam logic [31:0] EB  = 32'h0010_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef CORE_RUN_CTRL_HW_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  localparam int M_BOOT = 0;
  localparam int M_HALT = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  typedef struct {
    bit          rst;
    bit          run;
    bit          halt;
    bit          step;
    logic [31:0] pc;
    logic [31:0] insn;
    bit          bpv;
    logic [31:0] bpa;
  } in_t;

  typedef struct {
    in_t         i;
    bit          pe;
    bit          we;
    bit          h;
    logic [1:0]  c;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, halt_req, step_req;
  logic [31:0] pc, instruction, bp_addr;
  logic        bp_valid;
  logic        pc_en, wr_en, halted;
  logic [1:0]  cause;
  logic [31:0] instret;
  logic        pc_en_w4, wr_en_w4, halted_w4;
  logic [1:0]  cause_w4;
  logic [3:0]  instret_w4;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .XLEN(32), .CNT_W(32), .BOOT_HOLD(BOOT_HOLD), .START_RUN(START_RUN)
  ) u_dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .pc(pc), .instruction(instruction),
    .bp_valid(bp_valid), .bp_addr(bp_addr), .pc_en(pc_en), .wr_en(wr_en),
    .halted(halted), .cause(cause), .instret(instret)
  );

  core_run_ctrl #(
    .XLEN(32), .CNT_W(4), .BOOT_HOLD(BOOT_HOLD), .START_RUN(START_RUN)
  ) u_dut_w4 (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .pc(pc), .instruction(instruction),
    .bp_valid(bp_valid), .bp_addr(bp_addr), .pc_en(pc_en_w4), .wr_en(wr_en_w4),
    .halted(halted_w4), .cause(cause_w4), .instret(instret_w4)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model of the sequencer.
  int          m_mode;
  int          m_boot_left;
  bit          m_skip;
  logic [1:0]  m_cause;
  logic [31:0] m_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mk_in(bit r, bit run, bit halt, bit step,
                                logic [31:0] p, logic [31:0] insn, bit bpv);
    in_t x;
    x.rst = r;  x.run = run;  x.halt = halt;  x.step = step;
    x.pc = p;   x.insn = insn; x.bpv = bpv;   x.bpa = 32'h40;
    return x;
  endfunction

  function automatic vec_t mk_vec(bit r, bit run, bit halt, bit step, logic [31:0] insn,
                                  bit pe, bit we, bit h, logic [1:0] c, logic [31:0] cnt);
    vec_t v;
    v.i = mk_in(r, run, halt, step, 32'h100, insn, 1'b0);
    v.pe = pe; v.we = we; v.h = h; v.c = c; v.cnt = cnt;
    return v;
  endfunction

  function automatic bit m_stop(in_t i);
    bit bp;
    bp = BP_ON && i.bpv && (i.pc == i.bpa);
    return (i.insn == EB || bp) && !m_skip;
  endfunction

  function automatic bit m_pc_en(in_t i);
    return (m_mode == M_RUN || m_mode == M_STEP) && !m_stop(i);
  endfunction

  function automatic void model_reset();
    m_mode = M_BOOT; m_boot_left = BOOT_HOLD; m_skip = 1'b0;
    m_cause = 2'd0;  m_instret = 32'd0;
  endfunction

  function automatic void model_update(in_t i);
    bit stop;
    bit pe;
    if (!i.rst) begin
      model_reset();
      return;
    end
    stop = m_stop(i);
    pe   = m_pc_en(i);
    if (pe) begin
      m_instret = m_instret + 32'd1;
      m_skip    = 1'b0;
    end
    case (m_mode)
      M_BOOT: begin
        m_boot_left--;
        if (m_boot_left == 0) m_mode = (START_RUN != 0) ? M_RUN : M_HALT;
      end
      M_HALT: begin
        if (i.run) begin
          m_mode = M_RUN;  m_skip = 1'b1;
        end else if (i.step) begin
          m_mode = M_STEP; m_skip = 1'b1;
        end
      end
      M_RUN: begin
        if (stop) begin
          m_mode = M_HALT; m_cause = 2'd3;
        end else if (i.halt) begin
          m_mode = M_HALT; m_cause = 2'd1;
        end
      end
      default: begin
        m_mode  = M_HALT;
        m_cause = stop ? 2'd3 : 2'd2;
      end
    endcase
  endfunction

  task automatic apply(in_t i);
    rst = i.rst; run_req = i.run; halt_req = i.halt; step_req = i.step;
    pc = i.pc;   instruction = i.insn; bp_valid = i.bpv; bp_addr = i.bpa;
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, advance model after posedge.
  task automatic cycle(input in_t i, input bit use_exp, input bit pe, input bit we,
                       input bit h, input logic [1:0] c, input logic [31:0] cnt,
                       input string tag);
    bit xpe, xwe, xh;
    logic [1:0]  xc;
    logic [31:0] xcnt;
    apply(i);
    #2;
    if (use_exp) begin
      xpe = pe; xwe = we; xh = h; xc = c; xcnt = cnt;
    end else begin
      xpe  = m_pc_en(i);
      xwe  = xpe && (i.insn != EB);
      xh   = (m_mode == M_HALT);
      xc   = m_cause;
      xcnt = m_instret;
    end
    check({tag, ".pc_en"},   32'(pc_en),      32'(xpe));
    check({tag, ".wr_en"},   32'(wr_en),      32'(xwe));
    check({tag, ".halted"},  32'(halted),     32'(xh));
    check({tag, ".cause"},   32'(cause),      32'(xc));
    check({tag, ".instret"}, instret,         xcnt);
    check({tag, ".inst_w4"}, 32'(instret_w4), 32'(xcnt[3:0]));
    @(posedge clk);
    model_update(i);
    @(negedge clk);
  endtask

  task automatic cycle_model(input in_t i, input string tag);
    cycle(i, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, tag);
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.rst  = ($urandom_range(0, 99) != 0);
    x.run  = ($urandom_range(0, 7) == 0);
    x.halt = ($urandom_range(0, 7) == 0);
    x.step = ($urandom_range(0, 3) == 0);
    x.pc   = 32'h3c + 32'($urandom_range(0, 3)) * 32'd4;
    x.insn = ($urandom_range(0, 5) == 0) ? EB : ($urandom() & 32'hFFFF_FF7F);
    x.bpv  = $urandom_range(0, 1) != 0;
    x.bpa  = 32'h40;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vq[$];
    logic [31:0] base;

    apply(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, NOP, 1'b0));
    @(posedge clk);
    model_reset();
    @(negedge clk);

    //                 rst run hlt stp insn   pe we h  c  cnt
    vq.push_back(mk_vec(0, 0, 0, 0, NOP,  0, 0, 0, 0, 0));
    vq.push_back(mk_vec(0, 0, 0, 0, NOP,  0, 0, 0, 0, 0));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 0, 0, 0));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 0, 0, 0));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 0, 0, 0));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 0, 0, 0));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  1, 1, 0, 0, 0));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  1, 1, 0, 0, 1));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  1, 1, 0, 0, 2));
    vq.push_back(mk_vec(1, 0, 1, 0, NOP,  1, 1, 0, 0, 3));
    vq.push_back(mk_vec(1, 0, 1, 0, NOP,  0, 0, 1, 1, 4));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 1, 1, 4));
    vq.push_back(mk_vec(1, 0, 0, 1, NOP,  0, 0, 1, 1, 4));
    vq.push_back(mk_vec(1, 0, 0, 1, NOP,  1, 1, 0, 1, 4));
    vq.push_back(mk_vec(1, 0, 0, 1, NOP,  0, 0, 1, 2, 5));
    vq.push_back(mk_vec(1, 0, 0, 1, NOP,  1, 1, 0, 2, 5));
    vq.push_back(mk_vec(1, 0, 0, 1, NOP,  0, 0, 1, 2, 6));
    vq.push_back(mk_vec(1, 0, 0, 1, NOP,  1, 1, 0, 2, 6));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 1, 2, 7));
    vq.push_back(mk_vec(1, 1, 0, 1, NOP,  0, 0, 1, 2, 7));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  1, 1, 0, 2, 7));
    vq.push_back(mk_vec(1, 0, 0, 0, EB,   0, 0, 0, 2, 8));
    vq.push_back(mk_vec(1, 0, 0, 0, EB,   0, 0, 1, 3, 8));
    vq.push_back(mk_vec(1, 1, 0, 0, EB,   0, 0, 1, 3, 8));
    vq.push_back(mk_vec(1, 0, 0, 0, EB,   1, 0, 0, 3, 8));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  1, 1, 0, 3, 9));
    vq.push_back(mk_vec(1, 0, 1, 0, EB,   0, 0, 0, 3, 10));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 1, 3, 10));
    vq.push_back(mk_vec(1, 1, 0, 0, NOP,  0, 0, 1, 3, 10));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  1, 1, 0, 3, 10));
    vq.push_back(mk_vec(0, 0, 0, 0, NOP,  1, 1, 0, 3, 11));
    vq.push_back(mk_vec(1, 0, 0, 0, NOP,  0, 0, 0, 0, 0));

    for (int k = 0; k < vq.size(); k++) begin
      cycle(vq[k].i, 1'b1, vq[k].pe, vq[k].we, vq[k].h, vq[k].c, vq[k].cnt,
            $sformatf("vec%0d", k));
    end

    // Finish boot, then walk the PC onto the breakpoint address.
    for (int k = 0; k < 2 * BOOT_HOLD && m_mode != M_RUN; k++) begin
      cycle_model(mk_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, NOP, 1'b0), "boot2");
    end
    base = m_instret;
    cycle(mk_in(1, 0, 0, 0, 32'h3c, NOP, 1), 1'b1, 1, 1, 0, 2'd0, base, "bp_before");
    cycle(mk_in(1, 0, 0, 0, 32'h40, NOP, 1), 1'b1, !BP_ON, !BP_ON, 0, 2'd0,
          base + 1, "bp_hit");
    cycle(mk_in(1, 0, 0, 0, 32'h40, NOP, 1), 1'b1, !BP_ON, !BP_ON, BP_ON,
          BP_ON ? 2'd3 : 2'd0, BP_ON ? base + 1 : base + 2, "bp_stopped");
    cycle(mk_in(1, 1, 0, 0, 32'h40, NOP, 1), 1'b1, !BP_ON, !BP_ON, BP_ON,
          BP_ON ? 2'd3 : 2'd0, BP_ON ? base + 1 : base + 3, "bp_resume");
    cycle(mk_in(1, 0, 0, 0, 32'h40, NOP, 1), 1'b1, 1, 1, 0,
          BP_ON ? 2'd3 : 2'd0, BP_ON ? base + 1 : base + 4, "bp_skip");
    cycle(mk_in(1, 0, 0, 0, 32'h44, NOP, 1), 1'b1, 1, 1, 0,
          BP_ON ? 2'd3 : 2'd0, BP_ON ? base + 2 : base + 5, "bp_after");

    // Run the narrow counter up to 15 and across the wrap.
    for (int k = 0; k < 40 && m_instret[3:0] != 4'hF; k++) begin
      cycle_model(mk_in(1, 0, 0, 0, 32'h100, NOP, 0), "wrap_run");
    end
    check("wrap_at15", 32'(instret_w4), 32'hF);
    cycle_model(mk_in(1, 0, 0, 0, 32'h100, NOP, 0), "wrap_edge");
    check("wrap_to0", 32'(instret_w4), 32'h0);

    for (int k = 0; k < 2000; k++) begin
      cycle_model(rand_in(), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/halt/step sequencer for the single-cycle RV32 core.
- Produces the PC-update enable and the architectural write enable (register file and data memory writes).
- Holds the core in a boot window after reset so instruction memory can be preloaded.
- Stops the core on EBREAK, on a debug halt request, or optionally on an address breakpoint. Counts retired instructions.

Parameters:
- XLEN, 32, width of pc, instruction and bp_addr.
- CNT_W, 32, width of instret counter.
- BOOT_HOLD, 4, cycles pc_en is held low after reset release (≥1).
- START_RUN, 1, state entered after boot: 1 = RUN, 0 = HALT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- run_req  in  1  level; leave HALT and run freely
- halt_req  in  1  level; stop after current instruction
- step_req  in  1  level; execute exactly one instruction from HALT
- pc  in  XLEN  current PC from program counter
- instruction  in  XLEN  current instruction memory output
- bp_valid  in  1  breakpoint armed (used only with macro)
- bp_addr  in  XLEN  breakpoint PC (used only with macro)
- pc_en  out  1  PC may load next PC this cycle
- wr_en  out  1  register file/data memory writes allowed this cycle
- halted  out  1  state == HALT
- cause  out  2  last stop reason: 0 none, 1 halt_req, 2 step done, 3 EBREAK/breakpoint
- instret  out  CNT_W  retired instruction count

Behaviour:
- All state updates on posedge clk; rst sampled only at clk edge. rst=0 at any time, including mid-RUN or mid-STEP, forces next state BOOT, boot_cnt=0, cause=0, instret=0, skip=0.
- During and directly after reset: pc_en=0, wr_en=0, halted=0, cause=0, instret=0.
- States: BOOT, HALT, RUN, STEP.
- stop_hit (combinational) = (instruction == 32'h0010_0073) OR bp_hit, AND NOT skip.
- pc_en (combinational):
  - RUN or STEP: pc_en = !stop_hit.
  - BOOT or HALT: pc_en = 0.
- wr_en = pc_en && (instruction != EBREAK).
- BOOT: boot_cnt increments each cycle. When boot_cnt == BOOT_HOLD-1, next state is RUN if START_RUN, else HALT. pc_en stays low for exactly BOOT_HOLD cycles after rst rises.
- HALT:
  - Priority: run_req > step_req. run_req → RUN; step_req → STEP.
  - halt_req is ignored.
  - Leaving HALT sets skip=1.
- RUN:
  - stop_hit → HALT with cause=3. The instruction is not executed and the PC stays at it.
  - Otherwise halt_req → HALT with cause=1. The current instruction retires (pc_en=1 this cycle).
  - stop_hit takes priority over halt_req.
- STEP: one cycle only, always → HALT.
  - cause=3 if stop_hit, else cause=2.
  - step_req held high therefore yields one step every 2 cycles.
- skip: cleared on the first cycle with pc_en=1 after it is set. Purpose: resuming from an EBREAK/breakpoint executes that instruction once. For EBREAK this means pc_en=1 with wr_en=0.
- cause holds its value until the next stop. It is cleared only by reset.
- instret: +1 on every cycle with pc_en=1, including skipped EBREAK. Wraps modulo 2^CNT_W.

Optional Feature:
- Macro: CORE_RUN_CTRL_HW_BREAKPOINT_EN.
- Defined: bp_hit = bp_valid && (pc == bp_addr).
- Undefined: bp_hit = 0; bp_valid and bp_addr are ignored but the ports remain present. Only EBREAK produces cause=3.

Decomposition:
- Shared defs package core_ctrl_defs holds:
  - state encoding (BOOT=0, HALT=1, RUN=2, STEP=3)
  - cause codes (CAUSE_NONE/HALT/STEP/BRK)
  - EBREAK_INSN = 32'h0010_0073
- One natural sub-module: instret_counter (CNT_W-bit enabled wrapping counter with synchronous active-low clear).

Test Plan:
- Reset + boot: rst=0 for 2 cycles, then 1; BOOT_HOLD=4, START_RUN=1 → pc_en=0 for 4 cycles, 1 on cycle 5; halted=0, instret=0 then +1 per cycle.
- Halt: in RUN, halt_req=1 at cycle N → pc_en=1 at N, 0 from N+1; halted=1, cause=1; instret frozen at its N+1 value.
- Step: HALT with step_req held 6 cycles → pc_en pulses on 3 alternate cycles, instret +3, cause=2, halted=1 between pulses; run_req and step_req together → RUN.
- EBREAK: instruction=32'h0010_0073 in RUN → pc_en=0, wr_en=0 same cycle, HALT with cause=3. Then run_req=1 → pc_en=1, wr_en=0 for one cycle, then normal RUN.
- Breakpoint (macro on): bp_valid=1, bp_addr=0x40, pc reaches 0x40 → pc_en=0 that cycle, cause=3. Macro off, same stimulus → no halt.
- Reset mid-RUN: instret=0x1234, rst=0 one cycle → next cycle state BOOT, instret=0, pc_en=0, cause=0; wrap check: CNT_W=4 from 15 → 0.
